multiply_multimode: RTL and testbench

- Iterative Booth multiplier that replaces the fixed signed-only shift-add multiplier.
- Each operand has its own signedness select, so one instance covers MUL/MULH/MULHSU/MULHU in the M-extension execute path.
- Retires radix-2 (1 bit) or radix-4 (2 bits) of the multiplier per cycle.
- Supports kill (pipeline flush) and back-to-back issue.

---
 rtl/multiply_multimode_if.sv | 27 ++
 rtl/multiply_multimode.sv | 133 +++++++++++++
 tb/tb_multiply_multimode.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multiply_multimode_if.sv
// Request/response bundle for the multi-mode iterative multiplier.
interface multiply_multimode_if #(
  parameter int unsigned A_W = 32,
  parameter int unsigned B_W = 32
);
  localparam int unsigned O_W = A_W + B_W;

  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           a_signed;
  logic           b_signed;
  logic           stb;
  logic           kill;
  logic [O_W-1:0] o;
  logic           ack;
  logic           busy;

  modport master (
    output a, b, a_signed, b_signed, stb, kill,
    input  o, ack, busy
  );

  modport slave (
    input  a, b, a_signed, b_signed, stb, kill,
    output o, ack, busy
  );
endinterface

// File: rtl/multiply_multimode.sv
// Iterative radix-2 / radix-4 Booth multiplier with per-operand signedness,
// kill and back-to-back issue. Operands are widened by one bit so that a
// single signed Booth core covers MUL/MULH/MULHSU/MULHU.
module multiply_multimode #(
  parameter int unsigned A_W = 32,
  parameter int unsigned B_W = 32,
  parameter int unsigned BPC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  multiply_multimode_if.slave  bus
);
  localparam int unsigned BPC_S   = (BPC == 0) ? 1 : BPC;
  localparam int unsigned O_W     = A_W + B_W;
  localparam int unsigned N_STEPS = (B_W + 1 + BPC_S - 1) / BPC_S;
  localparam int unsigned MW      = N_STEPS * BPC_S;   // padded multiplier width
  localparam int unsigned HW      = A_W + 2;           // accumulator high part
  localparam int unsigned ACC_W   = HW + MW + 1;       // {hi, multiplier, booth bit}
  localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);

  if (BPC != 1 && BPC != 2) begin : g_bad_bpc
    $error("multiply_multimode: BPC must be 1 or 2");
  end
  if (A_W < 2 || B_W < 2) begin : g_bad_width
    $error("multiply_multimode: A_W and B_W must be >= 2");
  end

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]      a_q, a_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [O_W-1:0]     o_q, o_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;

  logic [HW-1:0]      addend;
  logic [HW-1:0]      hi_sum;
  logic [ACC_W-1:0]   acc_step;

  // One Booth step: recode the low multiplier bits, add into the high part, shift.
  always_comb begin
    addend = '0;
    if (BPC == 1) begin
      case (acc_q[1:0])
        2'b01:   addend = a_q;
        2'b10:   addend = -a_q;
        default: addend = '0;
      endcase
    end else begin
      case (acc_q[2:0])
        3'b001, 3'b010: addend = a_q;
        3'b011:         addend = {a_q[HW-2:0], 1'b0};
        3'b100:         addend = -{a_q[HW-2:0], 1'b0};
        3'b101, 3'b110: addend = -a_q;
        default:        addend = '0;
      endcase
    end
    hi_sum   = acc_q[ACC_W-1 -: HW] + addend;
    acc_step = ACC_W'($signed({hi_sum, acc_q[ACC_W-HW-1:0]}) >>> BPC_S);
  end

  // Next-state and output logic; kill outranks a new request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    o_d     = o_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.stb && !bus.kill) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          a_d     = HW'(signed'({bus.a_signed & bus.a[A_W-1], bus.a}));
          acc_d   = {{HW{1'b0}},
                     MW'(signed'({bus.b_signed & bus.b[B_W-1], bus.b})),
                     1'b0};
        end
      end
      S_RUN: begin
        if (bus.kill) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_STEPS - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
            cnt_d   = '0;
            o_d     = acc_step[O_W:1];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o    = o_q;
  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_multiply_multimode.sv
// Directed bench for multiply_multimode: 32x32 in radix-4 and radix-2,
// 13x7 in radix-4 and radix-2, plus back-to-back, kill and reset cases.
module tb_multiply_multimode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multiply_multimode_if #(.A_W(32), .B_W(32)) m2 ();
  multiply_multimode_if #(.A_W(32), .B_W(32)) m1 ();
  multiply_multimode_if #(.A_W(13), .B_W(7))  s2 ();
  multiply_multimode_if #(.A_W(13), .B_W(7))  s1 ();

  multiply_multimode #(.A_W(32), .B_W(32), .BPC(2)) u_m2 (.clk(clk), .rst(rst), .bus(m2));
  multiply_multimode #(.A_W(32), .B_W(32), .BPC(1)) u_m1 (.clk(clk), .rst(rst), .bus(m1));
  multiply_multimode #(.A_W(13), .B_W(7),  .BPC(2)) u_s2 (.clk(clk), .rst(rst), .bus(s2));
  multiply_multimode #(.A_W(13), .B_W(7),  .BPC(1)) u_s1 (.clk(clk), .rst(rst), .bus(s1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set32(input logic [31:0] a, input logic [31:0] b, input logic as_, input logic bs_);
    m2.a = a; m2.b = b; m2.a_signed = as_; m2.b_signed = bs_;
    m1.a = a; m1.b = b; m1.a_signed = as_; m1.b_signed = bs_;
  endtask

  // Issue on both 32-bit instances; check product, latency and busy span.
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic as_, input logic bs_, input logic [63:0] exp);
    int n, l2, l1, bz2;
    logic [63:0] o2, o1;
    n = 0; l2 = 0; l1 = 0; bz2 = 0; o2 = '0; o1 = '0;
    tick();
    set32(a, b, as_, bs_);
    m2.stb = 1'b1; m1.stb = 1'b1;
    tick();
    m2.stb = 1'b0; m1.stb = 1'b0;
    while ((l2 == 0 || l1 == 0) && n < 100) begin
      if (m2.busy) bz2++;
      if (m2.ack && l2 == 0) begin l2 = n; o2 = m2.o; end
      if (m1.ack && l1 == 0) begin l1 = n; o1 = m1.o; end
      if (l2 == 0 || l1 == 0) begin tick(); n++; end
    end
    chk({tag, " o r4"}, o2, exp);
    chk({tag, " o r2"}, o1, exp);
    chk({tag, " lat r4"}, 64'(l2), 64'd17);
    chk({tag, " lat r2"}, 64'(l1), 64'd33);
    chk({tag, " busy r4"}, 64'(bz2), 64'd17);
  endtask

  // Issue on both 13x7 instances.
  task automatic run13(input string tag, input logic [12:0] a, input logic [6:0] b,
                       input logic as_, input logic bs_, input logic [19:0] exp);
    int n, l2, l1, bz2;
    logic [19:0] o2, o1;
    n = 0; l2 = 0; l1 = 0; bz2 = 0; o2 = '0; o1 = '0;
    tick();
    s2.a = a; s2.b = b; s2.a_signed = as_; s2.b_signed = bs_;
    s1.a = a; s1.b = b; s1.a_signed = as_; s1.b_signed = bs_;
    s2.stb = 1'b1; s1.stb = 1'b1;
    tick();
    s2.stb = 1'b0; s1.stb = 1'b0;
    while ((l2 == 0 || l1 == 0) && n < 50) begin
      if (s2.busy) bz2++;
      if (s2.ack && l2 == 0) begin l2 = n; o2 = s2.o; end
      if (s1.ack && l1 == 0) begin l1 = n; o1 = s1.o; end
      if (l2 == 0 || l1 == 0) begin tick(); n++; end
    end
    chk({tag, " o r4"}, 64'(o2), 64'(exp));
    chk({tag, " o r2"}, 64'(o1), 64'(exp));
    chk({tag, " lat r4"}, 64'(l2), 64'd4);
    chk({tag, " lat r2"}, 64'(l1), 64'd8);
    chk({tag, " busy r4"}, 64'(bz2), 64'd4);
  endtask

  initial begin
    int n, acks;
    logic [12:0] ra;
    logic [6:0]  rb;
    logic        ras, rbs;
    longint      av, bv, pv;

    set32('0, '0, 1'b0, 1'b0);
    m2.stb = 1'b0; m2.kill = 1'b0; m1.stb = 1'b0; m1.kill = 1'b0;
    s2.a = '0; s2.b = '0; s2.a_signed = 1'b0; s2.b_signed = 1'b0; s2.stb = 1'b0; s2.kill = 1'b0;
    s1.a = '0; s1.b = '0; s1.a_signed = 1'b0; s1.b_signed = 1'b0; s1.stb = 1'b0; s1.kill = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("reset o", m2.o, 64'd0);
    chk("reset ack", 64'(m2.ack), 64'd0);
    chk("reset busy", 64'(m2.busy), 64'd0);

    // 32x32 mode sweep
    run32("ss m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001);
    run32("uu max",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001);
    run32("su max",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001);
    run32("ss min",   32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000);

    // Back-to-back on the radix-4 instance; pulses while busy are ignored
    tick();
    m2.a = 32'd7; m2.b = 32'd6; m2.a_signed = 1'b1; m2.b_signed = 1'b1; m2.stb = 1'b1;
    tick();
    m2.stb = 1'b0; m2.a = 32'd9; m2.b = 32'd9;
    n = 0;
    while (!m2.ack && n < 40) begin
      m2.stb = (n == 3 || n == 4 || n == 10);
      tick();
      n++;
    end
    chk("b2b first lat", 64'(n), 64'd17);
    chk("b2b first o", m2.o, 64'd42);
    chk("b2b ack busy", 64'(m2.busy), 64'd0);
    m2.a = 32'hFFFFFFFD; m2.b = 32'd5; m2.stb = 1'b1;
    tick();
    m2.stb = 1'b0;
    chk("b2b accepted busy", 64'(m2.busy), 64'd1);
    chk("b2b o held", m2.o, 64'd42);
    n = 0;
    while (!m2.ack && n < 40) begin tick(); n++; end
    chk("b2b second lat", 64'(n), 64'd17);
    chk("b2b second o", m2.o, 64'hFFFFFFFFFFFFFFF1);
    tick();
    chk("ack single pulse", 64'(m2.ack), 64'd0);
    acks = 0;
    repeat (20) begin if (m2.ack) acks++; tick(); end
    chk("no extra ack", 64'(acks), 64'd0);

    // Kill at step 5 of 3x4
    m2.a = 32'd3; m2.b = 32'd4; m2.stb = 1'b1;
    tick();
    m2.stb = 1'b0;
    repeat (4) tick();
    m2.kill = 1'b1;
    tick();
    m2.kill = 1'b0;
    chk("kill busy", 64'(m2.busy), 64'd0);
    chk("kill o held", m2.o, 64'hFFFFFFFFFFFFFFF1);
    acks = 0;
    repeat (25) begin if (m2.ack) acks++; tick(); end
    chk("kill no ack", 64'(acks), 64'd0);
    // kill with stb while idle: no accept
    m2.stb = 1'b1; m2.kill = 1'b1;
    tick();
    m2.stb = 1'b0; m2.kill = 1'b0;
    chk("kill idle no accept", 64'(m2.busy), 64'd0);
    m2.stb = 1'b1;
    tick();
    m2.stb = 1'b0;
    n = 0;
    while (!m2.ack && n < 40) begin tick(); n++; end
    chk("after kill lat", 64'(n), 64'd17);
    chk("after kill o", m2.o, 64'd12);

    // 13x7 directed vectors, all four modes, edges
    run13("13 uu max", 13'h1FFF, 7'h7F, 1'b0, 1'b0, 20'hFDF81);
    run13("13 ss m1",  13'h1FFF, 7'h7F, 1'b1, 1'b1, 20'h00001);
    run13("13 su max", 13'h1FFF, 7'h7F, 1'b1, 1'b0, 20'hFFF81);
    run13("13 us max", 13'h1FFF, 7'h7F, 1'b0, 1'b1, 20'hFE001);
    run13("13 ss min", 13'h1000, 7'h40, 1'b1, 1'b1, 20'h40000);
    run13("13 su min", 13'h1000, 7'h40, 1'b1, 1'b0, 20'hC0000);
    run13("13 us min", 13'h1000, 7'h40, 1'b0, 1'b1, 20'hC0000);
    run13("13 uu 41",  13'h1000, 7'h41, 1'b0, 1'b0, 20'h41000);
    run13("13 ss 41",  13'h1000, 7'h41, 1'b1, 1'b1, 20'h3F000);
    run13("13 ss pmax",13'h0FFF, 7'h3F, 1'b1, 1'b1, 20'h3EFC1);
    run13("13 ss zero",13'h0000, 7'h7F, 1'b1, 1'b1, 20'h00000);
    run13("13 uu mid", 13'h007B, 7'h55, 1'b0, 1'b0, 20'h028D7);
    run13("13 ss mid", 13'h007B, 7'h55, 1'b1, 1'b1, 20'hFEB57);

    // Random 13x7 sweep against an integer reference
    for (int i = 0; i < 8; i++) begin
      ra  = 13'($urandom);
      rb  = 7'($urandom);
      ras = i[0];
      rbs = i[1];
      av  = ras ? longint'(signed'(ra)) : longint'(ra);
      bv  = rbs ? longint'(signed'(rb)) : longint'(rb);
      pv  = av * bv;
      run13("13 rand", ra, rb, ras, rbs, 20'(pv));
    end

    // Reset mid-operation
    tick();
    set32(32'd1000, 32'd1000, 1'b0, 1'b0);
    m2.stb = 1'b1; m1.stb = 1'b1;
    tick();
    m2.stb = 1'b0; m1.stb = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst o", m2.o, 64'd0);
    chk("rst busy", 64'(m2.busy), 64'd0);
    chk("rst ack", 64'(m2.ack), 64'd0);
    chk("rst o r2", m1.o, 64'd0);
    acks = 0;
    repeat (40) begin if (m2.ack || m1.ack) acks++; tick(); end
    chk("rst no ack", 64'(acks), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
